// File: rtl/audio_frame_pkg.sv
// Shared defaults, derived widths and reader state type for the audio frame buffer.
package audio_frame_pkg;

    localparam int DEF_SAMPLE_W  = 16;
    localparam int DEF_CHANNELS  = 2;
    localparam int DEF_FRAME_LEN = 64;
    localparam int DEF_DECIM     = 1;

    // Widths for the default configuration; modules recompute these from their own parameters.
    localparam int ADDR_W = $clog2(DEF_FRAME_LEN);
    localparam int DATA_W = DEF_CHANNELS * DEF_SAMPLE_W;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_FETCH,
        RD_VALID
    } rd_state_e;

    // Counter width that stays at least one bit for a modulus of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_deser.sv
// I2S receiver oversampled in the system clock: synchronisers, BCLK rise detect,
// per-slot bit counter, left/right shift registers and a one-cycle pair_valid pulse.
module i2s_deser #(
    parameter int SAMPLE_W = 16,
    parameter int CHANNELS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bclk,
    input  logic                lrck,
    input  logic                dat,
    output logic                pair_valid,
    output logic [SAMPLE_W-1:0] left_sample,
    output logic [SAMPLE_W-1:0] right_sample
);

    localparam int CW = $clog2(SAMPLE_W + 1);

    logic [1:0]    bclk_sync;
    logic [1:0]    lrck_sync;
    logic [1:0]    dat_sync;
    logic          bclk_prev;
    logic          bclk_rise;
    logic          lrck_s;
    logic          dat_s;
    logic          lrck_last;
    logic          slot_active;
    logic [CW-1:0] bit_cnt;
    logic          last_bit_of_pair;

    assign bclk_rise = bclk_sync[1] & ~bclk_prev;
    assign lrck_s    = lrck_sync[1];
    assign dat_s     = dat_sync[1];

    // Pair closes on the right slot normally, on the left slot in mono mode.
    assign last_bit_of_pair = (bit_cnt == CW'(SAMPLE_W - 1)) &&
                              ((CHANNELS == 1) ? !lrck_last : lrck_last);

    // Two-flop synchronisers plus the delayed BCLK copy used for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], bclk};
            lrck_sync <= {lrck_sync[0], lrck};
            dat_sync  <= {dat_sync[0], dat};
            bclk_prev <= bclk_sync[1];
        end
    end

    // Slot tracking and MSB-first shifting on each BCLK rise.
    // slot_active keeps bits from a slot already in progress at reset out of the registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lrck_last    <= 1'b0;
            slot_active  <= 1'b0;
            bit_cnt      <= '0;
            left_sample  <= '0;
            right_sample <= '0;
            pair_valid   <= 1'b0;
        end else begin
            pair_valid <= 1'b0;
            if (bclk_rise) begin
                if (lrck_s != lrck_last) begin
                    lrck_last   <= lrck_s;
                    bit_cnt     <= '0;
                    slot_active <= 1'b1;
                end else if (slot_active && (bit_cnt < CW'(SAMPLE_W))) begin
                    bit_cnt <= bit_cnt + CW'(1);
                    if (!lrck_last) begin
                        left_sample <= {left_sample[SAMPLE_W-2:0], dat_s};
                    end else begin
                        right_sample <= {right_sample[SAMPLE_W-2:0], dat_s};
                    end
                    if (last_bit_of_pair) begin
                        pair_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/audio_frame_buffer.sv
// Codec capture path: I2S deserialiser, pair decimator, ping-pong frame banks and
// an Avalon-ST source with sop/eop and backpressure, all in the CLOCK_50 domain.
module audio_frame_buffer
    import audio_frame_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int DECIM     = DEF_DECIM
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         AUD_BCLK,
    input  logic                         AUD_ADCLRCK,
    input  logic                         AUD_ADCDAT,
    input  logic                         capture_en,
    input  logic                         clear_overflow,
    input  logic                         source_ready,
    output logic                         source_valid,
    output logic                         source_sop,
    output logic                         source_eop,
    output logic [CHANNELS*SAMPLE_W-1:0] source_data,
    output logic                         overflow
);

    localparam int AW    = $clog2(FRAME_LEN);
    localparam int DW    = CHANNELS * SAMPLE_W;
    localparam int DEC_W = cnt_width(DECIM);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

    logic                pair_valid;
    logic [SAMPLE_W-1:0] left_s;
    logic [SAMPLE_W-1:0] right_s;
    logic [DW-1:0]       pair_word;

    logic [DEC_W-1:0]    dec_cnt;
    logic                offer;

    logic [AW-1:0]       wr_addr;
    logic                wr_bank;
    logic                wr_en;
    logic                drop;
    logic [1:0]          full;
    logic [1:0]          full_set;
    logic [1:0]          full_clr;
    logic [DW-1:0]       mem [2*FRAME_LEN];

    rd_state_e           state_q;
    rd_state_e           state_d;
    logic [AW-1:0]       rd_addr;
    logic                rd_bank;
    logic                rd_last;
    logic                handshake;

    i2s_deser #(
        .SAMPLE_W (SAMPLE_W),
        .CHANNELS (CHANNELS)
    ) u_deser (
        .clk          (CLOCK_50),
        .reset        (reset),
        .bclk         (AUD_BCLK),
        .lrck         (AUD_ADCLRCK),
        .dat          (AUD_ADCDAT),
        .pair_valid   (pair_valid),
        .left_sample  (left_s),
        .right_sample (right_s)
    );

    // Truncating the concatenation keeps only the left field in mono mode.
    assign pair_word = DW'({right_s, left_s});

    assign offer = pair_valid && (dec_cnt == '0);

    // Modulo-DECIM pair counter; only count 0 reaches the writer.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            dec_cnt <= '0;
        end else if (pair_valid) begin
            dec_cnt <= (dec_cnt == DEC_W'(DECIM - 1)) ? '0 : dec_cnt + DEC_W'(1);
        end
    end

    // Writer decision for an offered pair: discard at a frame boundary when idle,
    // drop into overflow when the target bank is still full, otherwise write.
    always_comb begin
        wr_en    = 1'b0;
        drop     = 1'b0;
        full_set = '0;
        if (offer && !((wr_addr == '0) && !capture_en)) begin
            if (full[wr_bank]) begin
                drop = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (wr_addr == LAST_ADDR) begin
                    full_set[wr_bank] = 1'b1;
                end
            end
        end
    end

    // Write pointer and bank select.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_addr <= '0;
            wr_bank <= 1'b0;
        end else if (wr_en) begin
            if (wr_addr == LAST_ADDR) begin
                wr_addr <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_addr <= wr_addr + AW'(1);
            end
        end
    end

    // Frame storage, bank in the top address bit; contents need no reset.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= pair_word;
        end
    end

    // Full flags: writer sets and reader clears never target the same bank together.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            full <= '0;
        end else begin
            full <= (full & ~full_clr) | full_set;
        end
    end

    // Sticky overflow; a drop wins over a simultaneous clear.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign rd_last = (rd_addr == LAST_ADDR);

    // Reader next-state logic and bank release on the final handshake.
    always_comb begin
        state_d   = state_q;
        full_clr  = '0;
        handshake = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    state_d = RD_FETCH;
                end
            end
            RD_FETCH: begin
                state_d = RD_VALID;
            end
            RD_VALID: begin
                if (source_ready) begin
                    handshake = 1'b1;
                    if (rd_last) begin
                        full_clr[rd_bank] = 1'b1;
                        state_d = full[~rd_bank] ? RD_FETCH : RD_IDLE;
                    end else begin
                        state_d = RD_FETCH;
                    end
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // Reader state, read pointer and registered output data.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= RD_IDLE;
            rd_addr     <= '0;
            rd_bank     <= 1'b0;
            source_data <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RD_FETCH) begin
                source_data <= mem[{rd_bank, rd_addr}];
            end
            if (handshake) begin
                if (rd_last) begin
                    rd_addr <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_addr <= rd_addr + AW'(1);
                end
            end
        end
    end

    assign source_valid = (state_q == RD_VALID);
    assign source_sop   = source_valid && (rd_addr == '0);
    assign source_eop   = source_valid && rd_last;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench: two instances share the I2S stimulus, one with DECIM=1 and one with DECIM=3.
module tb_audio_frame_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        bclk, lrck, dat;
    logic        cap, clr, ready;
    logic        v, sop, eop, ovf;
    logic [31:0] data;
    logic        cap_d, ready_d;
    logic        d_v, d_sop, d_eop, d_ovf;
    logic [31:0] d_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] bq_data[$];
    bit          bq_sop[$];
    bit          bq_eop[$];
    logic [31:0] dq_data[$];
    bit          dq_sop[$];
    bit          dq_eop[$];

    always #5 clk = ~clk;

    audio_frame_buffer #(
        .SAMPLE_W  (16),
        .CHANNELS  (2),
        .FRAME_LEN (4),
        .DECIM     (1)
    ) dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .AUD_BCLK       (bclk),
        .AUD_ADCLRCK    (lrck),
        .AUD_ADCDAT     (dat),
        .capture_en     (cap),
        .clear_overflow (clr),
        .source_ready   (ready),
        .source_valid   (v),
        .source_sop     (sop),
        .source_eop     (eop),
        .source_data    (data),
        .overflow       (ovf)
    );

    audio_frame_buffer #(
        .SAMPLE_W  (16),
        .CHANNELS  (2),
        .FRAME_LEN (4),
        .DECIM     (3)
    ) dut_dec (
        .CLOCK_50       (clk),
        .reset          (reset),
        .AUD_BCLK       (bclk),
        .AUD_ADCLRCK    (lrck),
        .AUD_ADCDAT     (dat),
        .capture_en     (cap_d),
        .clear_overflow (clr),
        .source_ready   (ready_d),
        .source_valid   (d_v),
        .source_sop     (d_sop),
        .source_eop     (d_eop),
        .source_data    (d_data),
        .overflow       (d_ovf)
    );

    // Record every accepted beat of both sources.
    always @(negedge clk) begin
        if (v && ready) begin
            bq_data.push_back(data);
            bq_sop.push_back(sop);
            bq_eop.push_back(eop);
        end
        if (d_v && ready_d) begin
            dq_data.push_back(d_data);
            dq_sop.push_back(d_sop);
            dq_eop.push_back(d_eop);
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_queues();
        bq_data.delete(); bq_sop.delete(); bq_eop.delete();
        dq_data.delete(); dq_sop.delete(); dq_eop.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; cap = 1'b0; clr = 1'b0; ready = 1'b0; cap_d = 1'b0; ready_d = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        clear_queues();
    endtask

    // One BCLK period, 4 system cycles per phase; data changes on the falling edge.
    task automatic i2s_bit(input logic lr, input logic d);
        bclk = 1'b0; lrck = lr; dat = d;
        #40 bclk = 1'b1;
        #40;
    endtask

    task automatic preamble();
        i2s_bit(1'b1, 1'b0);
        i2s_bit(1'b1, 1'b0);
    endtask

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
        i2s_bit(1'b0, 1'b0);
        for (int i = 15; i >= 0; i--) i2s_bit(1'b0, l[i]);
        i2s_bit(1'b0, 1'b0);
        i2s_bit(1'b1, 1'b0);
        for (int i = 15; i >= 0; i--) i2s_bit(1'b1, r[i]);
        i2s_bit(1'b1, 1'b0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!v && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (v !== 1'b1) begin
            errors++;
            $display("FAIL %s: source_valid timeout, got %b required 1", tag, v);
        end
    endtask

    task automatic pulse_ready(input string tag);
        wait_valid(tag);
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (v !== 1'b0)     begin errors++; $display("FAIL rst_valid: got %b required 0", v); end
        checks++; if (sop !== 1'b0)   begin errors++; $display("FAIL rst_sop: got %b required 0", sop); end
        checks++; if (eop !== 1'b0)   begin errors++; $display("FAIL rst_eop: got %b required 0", eop); end
        checks++; if (data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h required 0", data); end
        checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL rst_ovf: got %b required 0", ovf); end
        checks++; if (d_v !== 1'b0)   begin errors++; $display("FAIL rst_dvalid: got %b required 0", d_v); end
        #1 reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] exp;
        do_reset();
        cap = 1'b1; ready = 1'b1;
        preamble();
        for (int n = 0; n < 4; n++) send_pair(16'h1234 + 16'(n), 16'hABCD + 16'(n));
        repeat (30) @(posedge clk);
        checks++;
        if (bq_data.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d required 4", bq_data.size()); end
        for (int i = 0; i < 4 && i < bq_data.size(); i++) begin
            exp = {16'hABCD + 16'(i), 16'h1234 + 16'(i)};
            checks++; if (bq_data[i] !== exp) begin errors++; $display("FAIL basic_data%0d: got %h required %h", i, bq_data[i], exp); end
            checks++; if (bq_sop[i] !== (i == 0)) begin errors++; $display("FAIL basic_sop%0d: got %b required %b", i, bq_sop[i], i == 0); end
            checks++; if (bq_eop[i] !== (i == 3)) begin errors++; $display("FAIL basic_eop%0d: got %b required %b", i, bq_eop[i], i == 3); end
        end
    endtask

    task automatic test_decim();
        logic [31:0] exp;
        do_reset();
        cap_d = 1'b1; ready_d = 1'b1;
        preamble();
        for (int n = 0; n < 12; n++) send_pair(16'(n), 16'h0100 + 16'(n));
        repeat (30) @(posedge clk);
        checks++;
        if (dq_data.size() !== 4) begin errors++; $display("FAIL decim_count: got %0d required 4", dq_data.size()); end
        for (int i = 0; i < 4 && i < dq_data.size(); i++) begin
            exp = {16'h0100 + 16'(3 * i), 16'(3 * i)};
            checks++; if (dq_data[i] !== exp) begin errors++; $display("FAIL decim_data%0d: got %h required %h", i, dq_data[i], exp); end
        end
        if (dq_data.size() == 4) begin
            checks++; if (dq_sop[0] !== 1'b1) begin errors++; $display("FAIL decim_sop: got %b required 1", dq_sop[0]); end
            checks++; if (dq_eop[3] !== 1'b1) begin errors++; $display("FAIL decim_eop: got %b required 1", dq_eop[3]); end
        end
        checks++; if (d_ovf !== 1'b0) begin errors++; $display("FAIL decim_ovf: got %b required 0", d_ovf); end
        cap_d = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        do_reset();
        cap = 1'b1;
        preamble();
        for (int n = 0; n < 4; n++) send_pair(16'h1000 + 16'(n), 16'h2000 + 16'(n));
        for (int k = 0; k < 3; k++) pulse_ready("bp_beat");
        wait_valid("bp_hold");
        exp = {16'h2003, 16'h1003};
        for (int k = 0; k < 50; k++) begin
            checks++;
            if (v !== 1'b1 || data !== exp || eop !== 1'b1) begin
                errors++;
                $display("FAIL bp_stable%0d: got valid=%b data=%h eop=%b required 1 %h 1", k, v, data, eop, exp);
            end
            @(negedge clk);
        end
        @(posedge clk); #1 ready = 1'b1;
        repeat (10) @(posedge clk);
        checks++;
        if (bq_data.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d required 4", bq_data.size()); end
        for (int i = 0; i < 4 && i < bq_data.size(); i++) begin
            exp = {16'h2000 + 16'(i), 16'h1000 + 16'(i)};
            checks++; if (bq_data[i] !== exp) begin errors++; $display("FAIL bp_data%0d: got %h required %h", i, bq_data[i], exp); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        do_reset();
        cap = 1'b1;
        preamble();
        for (int n = 0; n < 8; n++) send_pair(16'h3000 + 16'(n), 16'h4000 + 16'(n));
        repeat (5) @(posedge clk);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b required 0", ovf); end
        send_pair(16'h3008, 16'h4008);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", ovf); end
        checks++;
        if (v !== 1'b1 || sop !== 1'b1 || data !== 32'h40003000) begin
            errors++;
            $display("FAIL ovf_stall: got valid=%b sop=%b data=%h required 1 1 40003000", v, sop, data);
        end
        @(posedge clk); #1 ready = 1'b1;
        repeat (40) @(posedge clk);
        checks++;
        if (bq_data.size() !== 8) begin errors++; $display("FAIL ovf_count: got %0d required 8", bq_data.size()); end
        for (int i = 0; i < 8 && i < bq_data.size(); i++) begin
            exp = {16'h4000 + 16'(i), 16'h3000 + 16'(i)};
            checks++; if (bq_data[i] !== exp) begin errors++; $display("FAIL ovf_data%0d: got %h required %h", i, bq_data[i], exp); end
            checks++; if (bq_sop[i] !== ((i % 4) == 0)) begin errors++; $display("FAIL ovf_sop%0d: got %b required %b", i, bq_sop[i], (i % 4) == 0); end
            checks++; if (bq_eop[i] !== ((i % 4) == 3)) begin errors++; $display("FAIL ovf_eop%0d: got %b required %b", i, bq_eop[i], (i % 4) == 3); end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", ovf); end
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", ovf); end
    endtask

    task automatic test_capture_en();
        int nsop;
        logic [31:0] exp;
        do_reset();
        cap = 1'b1; ready = 1'b1;
        preamble();
        for (int n = 0; n < 2; n++) send_pair(16'h5000 + 16'(n), 16'h6000 + 16'(n));
        cap = 1'b0;
        for (int n = 2; n < 8; n++) send_pair(16'h5000 + 16'(n), 16'h6000 + 16'(n));
        repeat (30) @(posedge clk);
        nsop = 0;
        foreach (bq_sop[i]) if (bq_sop[i]) nsop++;
        checks++; if (bq_data.size() !== 4) begin errors++; $display("FAIL cap_count1: got %0d required 4", bq_data.size()); end
        checks++; if (nsop !== 1) begin errors++; $display("FAIL cap_sop1: got %0d required 1", nsop); end
        if (bq_data.size() >= 4) begin
            checks++; if (bq_data[3] !== 32'h60035003) begin errors++; $display("FAIL cap_last1: got %h required 60035003", bq_data[3]); end
        end
        cap = 1'b1;
        for (int n = 8; n < 12; n++) send_pair(16'h5000 + 16'(n), 16'h6000 + 16'(n));
        repeat (30) @(posedge clk);
        nsop = 0;
        foreach (bq_sop[i]) if (bq_sop[i]) nsop++;
        checks++; if (bq_data.size() !== 8) begin errors++; $display("FAIL cap_count2: got %0d required 8", bq_data.size()); end
        checks++; if (nsop !== 2) begin errors++; $display("FAIL cap_sop2: got %0d required 2", nsop); end
        if (bq_data.size() >= 8) begin
            for (int i = 4; i < 8; i++) begin
                exp = {16'h6004 + 16'(i), 16'h5004 + 16'(i)};
                checks++; if (bq_data[i] !== exp) begin errors++; $display("FAIL cap_data%0d: got %h required %h", i, bq_data[i], exp); end
            end
            checks++; if (bq_sop[4] !== 1'b1) begin errors++; $display("FAIL cap_sop4: got %b required 1", bq_sop[4]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        do_reset();
        cap = 1'b1;
        preamble();
        for (int n = 0; n < 4; n++) send_pair(16'h7000 + 16'(n), 16'h8000 + 16'(n));
        pulse_ready("rm_beat0");
        pulse_ready("rm_beat1");
        wait_valid("rm_beat2");
        checks++;
        if (data !== 32'h80027002 || sop !== 1'b0 || eop !== 1'b0) begin
            errors++;
            $display("FAIL rm_beat2: got data=%h sop=%b eop=%b required 80027002 0 0", data, sop, eop);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b required 0", v); end
        checks++; if (data !== 32'h0) begin errors++; $display("FAIL rm_data: got %h required 0", data); end
        reset = 1'b0;
        clear_queues();
        ready = 1'b1;
        preamble();
        for (int n = 0; n < 4; n++) send_pair(16'h9000 + 16'(n), 16'hA000 + 16'(n));
        repeat (30) @(posedge clk);
        checks++; if (bq_data.size() !== 4) begin errors++; $display("FAIL rm_count: got %0d required 4", bq_data.size()); end
        for (int i = 0; i < 4 && i < bq_data.size(); i++) begin
            exp = {16'hA000 + 16'(i), 16'h9000 + 16'(i)};
            checks++; if (bq_data[i] !== exp) begin errors++; $display("FAIL rm_data%0d: got %h required %h", i, bq_data[i], exp); end
        end
        if (bq_data.size() == 4) begin
            checks++; if (bq_sop[0] !== 1'b1) begin errors++; $display("FAIL rm_sop: got %b required 1", bq_sop[0]); end
            checks++; if (bq_eop[3] !== 1'b1) begin errors++; $display("FAIL rm_eop: got %b required 1", bq_eop[3]); end
        end
    endtask

    initial begin
        reset = 1'b1; bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
        cap = 1'b0; clr = 1'b0; ready = 1'b0; cap_d = 1'b0; ready_d = 1'b0;
        test_reset();
        test_basic();
        test_decim();
        test_backpressure();
        test_overflow();
        test_capture_en();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
